// File: rtl/call_stack.sv
// Return-address LIFO (DEPTH x AW) with sticky overflow/underflow flags; optional macro CALL_STACK_WRAP_EN.
// Latency: a push is visible on top_addr the cycle after it is clocked in; top_addr is combinational from the array.
// Backpressure: none; a push when full is dropped (or overwrites the oldest entry under CALL_STACK_WRAP_EN) and sets overflow.
module call_stack #(
    parameter int DEPTH = 4,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [AW-1:0] push_addr,
    output logic [AW-1:0] top_addr,
    output logic [4:0]    count,
    output logic          full,
    output logic          empty,
    output logic          overflow,
    output logic          underflow
);

    localparam int             SPW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [SPW-1:0] SP_LAST = SPW'(DEPTH - 1);
    localparam logic [4:0]     DEPTH_C = 5'(DEPTH);

    typedef enum logic [1:0] {
        EMPTY,
        PARTIAL,
        FULL
    } state_e;

    logic [AW-1:0]  mem_q [DEPTH];
    logic [SPW-1:0] sp_q, sp_d;
    logic [4:0]     count_q, count_d;
    logic           ovf_q, ovf_d;
    logic           udf_q, udf_d;

    logic [SPW-1:0] sp_inc, sp_dec;
    logic           wr_en;
    logic [SPW-1:0] wr_idx;
    logic [AW-1:0]  wr_dat;
    state_e         state;

    // The state register is count itself; the enum is a decoded view of it.
    always_comb begin
        if (count_q == 5'd0) begin
            state = EMPTY;
        end else if (count_q == DEPTH_C) begin
            state = FULL;
        end else begin
            state = PARTIAL;
        end
    end

    always_comb begin
        sp_inc = (sp_q == SP_LAST) ? '0 : sp_q + 1'b1;
        sp_dec = (sp_q == '0) ? SP_LAST : sp_q - 1'b1;
    end

    always_comb begin
        sp_d    = sp_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        udf_d   = udf_q;
        wr_en   = 1'b0;
        wr_idx  = sp_q;
        wr_dat  = push_addr;

        case (state)
            EMPTY: begin
                if (push) begin
                    wr_en   = 1'b1;
                    sp_d    = sp_inc;
                    count_d = count_q + 5'd1;
                end else if (pop) begin
                    udf_d = 1'b1;
                end
            end
            PARTIAL: begin
                if (push && pop) begin
                    wr_en  = 1'b1;
                    wr_idx = sp_dec;
                end else if (push) begin
                    wr_en   = 1'b1;
                    sp_d    = sp_inc;
                    count_d = count_q + 5'd1;
                end else if (pop) begin
                    sp_d    = sp_dec;
                    count_d = count_q - 5'd1;
                end
            end
            FULL: begin
                if (push && pop) begin
                    wr_en  = 1'b1;
                    wr_idx = sp_dec;
                end else if (push) begin
                    ovf_d = 1'b1;
`ifdef CALL_STACK_WRAP_EN
                    // sp points at the oldest entry when full, so this evicts it.
                    wr_en = 1'b1;
                    sp_d  = sp_inc;
`endif
                end else if (pop) begin
                    sp_d    = sp_dec;
                    count_d = count_q - 5'd1;
                end
            end
            default: begin
                sp_d    = sp_q;
                count_d = count_q;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sp_q    <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            sp_q    <= sp_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    // Array is not cleared; a write coinciding with reset is discarded.
    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            mem_q[wr_idx] <= wr_dat;
        end
    end

    assign top_addr  = (count_q == 5'd0) ? '0 : mem_q[sp_dec];
    assign count     = count_q;
    assign full      = (count_q == DEPTH_C);
    assign empty     = (count_q == 5'd0);
    assign overflow  = ovf_q;
    assign underflow = udf_q;

endmodule

// File: doc/call_stack.md
CALL_STACK -- requirements
Module: call_stack

Interface
REQ-001 The block SHALL expose parameter DEPTH, default 4, giving the number of stored return addresses (legal range 2..16).
REQ-002 The block SHALL expose parameter AW, default 8, giving the address width in bits.
REQ-003 Port clk SHALL be an input, 1 bit, the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst SHALL be an input, 1 bit, the reset; it SHALL be asynchronous and active-high.
REQ-005 Port push SHALL be an input, 1 bit, requesting that push_addr be stored on top of the stack.
REQ-006 Port pop SHALL be an input, 1 bit, requesting removal of the top entry.
REQ-007 Port push_addr SHALL be an input, AW bits, carrying the return address to store.
REQ-008 Port top_addr SHALL be an output, AW bits, carrying the current top entry, or 0 when the stack is empty.
REQ-009 Port count SHALL be an output, 5 bits, giving the number of valid entries (0..DEPTH).
REQ-010 Ports full and empty SHALL be outputs, 1 bit each, asserted when count==DEPTH and count==0 respectively.
REQ-011 Ports overflow and underflow SHALL be outputs, 1 bit each, acting as sticky error flags.

Function
REQ-012 The block SHALL be a LIFO built from a DEPTH x AW register array, a write pointer sp, and count.
REQ-013 The block SHALL run a state machine with states EMPTY, PARTIAL and FULL, with the state encoded by count.
REQ-014 A push with no pop SHALL write push_addr at index sp, increment sp, and increment count, all in one cycle.
REQ-015 A pop with no push SHALL decrement sp and count in one cycle.
REQ-016 top_addr SHALL be combinational from array[sp-1], so data pushed in cycle N is visible in cycle N+1 (1-cycle latency).
REQ-017 Push and pop in the same cycle with count>0 SHALL overwrite the top entry with push_addr, leaving count and sp unchanged.
REQ-018 Push and pop in the same cycle with count==0 SHALL be treated as a push only.
REQ-019 A pop when empty SHALL leave all state unchanged and set underflow.
REQ-020 A push when full, with no pop, SHALL be handled as defined in REQ-027 / REQ-028.
REQ-021 sp arithmetic SHALL be modulo DEPTH.
REQ-022 Once set, overflow and underflow SHALL remain set until reset.
REQ-023 Stored data SHALL be exactly push_addr, with no arithmetic applied.

Reset
REQ-024 rst high SHALL asynchronously force sp=0, count=0, overflow=0 and underflow=0, giving empty=1, full=0 and top_addr=0.
REQ-025 Array contents need not be cleared on reset, but top_addr SHALL read 0 while empty.
REQ-026 Reset asserted mid-operation SHALL discard any same-cycle push or pop.

Configuration
REQ-027 Without macro CALL_STACK_WRAP_EN, a push when full SHALL be dropped, with state unchanged, and SHALL set overflow.
REQ-028 With CALL_STACK_WRAP_EN defined, a push when full SHALL write at sp, advance sp modulo DEPTH, keep count==DEPTH, discard the oldest entry, and set overflow.

Verification
REQ-029 Reset, then push 0x10, 0x20, 0x30 -> count=3; top_addr=0x30; after one pop, top_addr=0x20.
REQ-030 With DEPTH=4, push 0x01..0x04 -> full=1; push 0x05 -> without wrap: top_addr=0x04, overflow=1; with wrap: top_addr=0x05, and 4 pops yield 0x05, 0x04, 0x03, 0x02.
REQ-031 Pop on an empty stack -> underflow=1, count=0, top_addr=0; a subsequent push 0xAA -> top_addr=0xAA and underflow stays 1.
REQ-032 With count=2 and top=0x22, push 0x99 and pop in the same cycle -> count=2, top_addr=0x99; the next pop exposes the prior second entry.
REQ-033 Push and pop in the same cycle while empty -> count=1, top_addr=push_addr.
REQ-034 Assert rst asynchronously between clock edges while count=3 -> empty=1, count=0, and flags clear immediately without waiting for a clock edge.
